spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Register-access sequencer that sits directly upstream of the chip-select SPI master (`SPI_Master_w_CS`). It converts single host register read/write requests into a two-byte chip-select transaction: an address byte, then a data byte. For writes the data byte carries the write data. For reads it carries a dummy byte, and the second MISO byte is returned. Typical use is the watch sensor and display-controller register buses.

## Interface
Parameters:
- MAX_BYTES_PER_CS, 2, must equal the SPI master's setting; must be ≥ 2; sets the width CW = clog2(MAX_BYTES_PER_CS+1).
- DUMMY_BYTE, 8'h00, byte sent in the data slot of a read.
- TIMEOUT_CLKS, 1024, maximum clk cycles spent in any single wait state before aborting.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_rw  in  1  1 = read, 0 = write.
- i_addr  in  7  register address.
- i_wdata  in  8  write data.
- o_busy  out  1  high whenever state ≠ IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done; 1 = timeout abort.
- o_rdata  out  8  read data; holds until the next read completes.
- o_MOSI_Count  out  CW  bytes per CS; constant 2.
- o_MOSI_Byte  out  8  byte to the SPI master.
- o_MOSI_DV  out  1  one-cycle data-valid pulse to the SPI master.
- i_MOSI_Ready  in  1  SPI master ready.
- i_MISO_DV  in  1  SPI master received-byte pulse.
- i_MISO_Byte  in  8  received byte.
- i_MISO_Count  in  CW  master's received-byte index; informational, not used for control.

## Operation
- **Request accept.** In IDLE with i_req=1, latch i_rw, i_addr and i_wdata. i_req in any other state is ignored; there is no queue.
- **Byte formation.** Byte0 = {rw, addr[6:0]}. Byte1 = rw ? DUMMY_BYTE : wdata.
- **States:**
  - IDLE → SEND0 on accept.
  - SEND0: when i_MOSI_Ready=1, pulse o_MOSI_DV with Byte0 → WAIT0.
  - WAIT0: wait until i_MOSI_Ready has been seen low and then high → SEND1.
  - SEND1: when i_MOSI_Ready=1, pulse o_MOSI_DV with Byte1 → WAIT_RX.
  - WAIT_RX: wait until the internal MISO counter reaches 2 → DONE.
  - DONE: o_done=1 for one cycle → IDLE.
- **MISO capture.**
  - An internal 2-bit counter clears on accept and increments on each i_MISO_DV while busy.
  - MISO pulses may arrive during WAIT0, SEND1 or WAIT_RX; all of them are counted.
  - i_MISO_Byte is written to o_rdata only when i_MISO_DV=1, counter=1 and rw=1. Byte index 0 is discarded.
  - i_MISO_DV seen in IDLE is ignored.
- **Writes.** o_rdata is unchanged.
- **Timeout.**
  - A counter clears on every state change and increments each cycle in SEND0, WAIT0, SEND1 and WAIT_RX.
  - When it reaches TIMEOUT_CLKS-1 the block goes to DONE with o_err=1. No further o_MOSI_DV is issued and o_rdata is unchanged.
- **Normal completion.** o_err=0 with o_done.
- **Reset (rst=0, any time).** State goes to IDLE and both counters clear. Output reset values:
  - o_busy=0, o_done=0, o_err=0, o_MOSI_DV=0.
  - o_rdata=0, o_MOSI_Byte=0.
  - o_MOSI_Count=2.
- **Reset mid-transaction.** The SPI master must be reset on the same rst; the SPI master's half-finished CS is not resumed.

## Timing
- All outputs are registered.
- **Accept.** i_req sampled high at edge N ⇒ o_busy=1 after edge N and state is SEND0.
- **Earliest first byte.** If i_MOSI_Ready=1 in SEND0, o_MOSI_DV is high for exactly the cycle after edge N+1, with o_MOSI_Byte=Byte0.
- **o_MOSI_Byte stability.** o_MOSI_Byte is stable for the DV cycle and holds until the next DV.
- **DV spacing.** Two DV pulses are never adjacent. There are at least 2 cycles between them because of WAIT0's low-then-high requirement.
- **Byte1 deadline.** Byte1's DV must be issued while the master still holds CS_L low. Guaranteed because SEND1 reacts within 1 cycle of ready rising.
- **Completion.** Last i_MISO_DV at edge M ⇒ state DONE after M. o_done is high for the cycle after edge M+1. o_busy falls with the end of DONE. o_rdata is valid no later than o_done.
- **Back-to-back.** A new i_req can be accepted on the first IDLE cycle after DONE, with no dead cycles beyond that.

## Test plan
- **Write, loopback MISO=MOSI.** Write addr 0x0F, data 0x2A → master sees DV bytes 0x0F then 0x2A in one CS; o_done pulses once with o_err=0; o_rdata stays 0x00.
- **Read with slave model.** Read addr 0x75; slave returns 0xFF then 0x68 → MOSI bytes 0xF5, 0x00; o_rdata=0x68 at o_done; byte 0xFF is never visible on o_rdata.
- **Busy collision.** Hold i_req high and change i_addr during a transaction → exactly one transaction with the originally latched address, then a second one accepted after IDLE.
- **Timeout.** Tie i_MOSI_Ready=0 with TIMEOUT_CLKS=16 → no o_MOSI_DV; o_done with o_err=1 after 16 busy cycles in SEND0; o_rdata unchanged.
- **Reset mid-read.** Assert rst low during WAIT_RX → all outputs take their reset values immediately; after release, a read of addr 0x01 returning 0x5A completes normally with o_rdata=0x5A.
- **Stray MISO pulse.** i_MISO_DV pulses in IDLE, then read addr 0x02 returning 0x33 → o_rdata=0x33 (the stray pulse is not counted).

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer: turns one host read/write request into a two-byte
// chip-select SPI transaction (address byte, then data/dummy byte).
module spi_reg_ctrl #(
  parameter int unsigned MAX_BYTES_PER_CS = 2,
  parameter logic [7:0]  DUMMY_BYTE       = 8'h00,
  parameter int unsigned TIMEOUT_CLKS     = 1024,
  localparam int unsigned CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic          i_rw,
  input  logic [6:0]    i_addr,
  input  logic [7:0]    i_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [7:0]    o_rdata,
  output logic [CW-1:0] o_MOSI_Count,
  output logic [7:0]    o_MOSI_Byte,
  output logic          o_MOSI_DV,
  input  logic          i_MOSI_Ready,
  input  logic          i_MISO_DV,
  input  logic [7:0]    i_MISO_Byte,
  input  logic [CW-1:0] i_MISO_Count
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND0   = 3'd1,
    WAIT0   = 3'd2,
    SEND1   = 3'd3,
    WAIT_RX = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          rw_q;
  logic [6:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [1:0]    rx_cnt_q;
  logic [TW-1:0] tmo_q;
  logic          saw_low_q;
  logic          abort_q;
  logic [7:0]    rx_hold_q;

  logic          accept;
  logic          in_wait;
  logic          tmo_hit;
  logic          to_abort;
  logic          dv_d;
  logic [7:0]    byte_d;
  logic [2:0]    rx_sum;
  logic [7:0]    byte0;
  logic [7:0]    byte1;

  // The master's received-byte index is informational only.
  logic unused_miso_count;
  assign unused_miso_count = ^i_MISO_Count;

  assign accept  = (state_q == IDLE) && i_req;
  assign in_wait = (state_q == SEND0) || (state_q == WAIT0) ||
                   (state_q == SEND1) || (state_q == WAIT_RX);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CLKS - 1));
  assign rx_sum  = {1'b0, rx_cnt_q} + {2'b00, i_MISO_DV};
  assign byte0   = {rw_q, addr_q};
  assign byte1   = rw_q ? DUMMY_BYTE : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and next values of the registered SPI-side outputs.
  always_comb begin
    state_d  = state_q;
    dv_d     = 1'b0;
    byte_d   = o_MOSI_Byte;
    to_abort = 1'b0;
    unique case (state_q)
      IDLE: if (i_req) state_d = SEND0;
      SEND0: begin
        if (i_MOSI_Ready) begin
          state_d = WAIT0;
          dv_d    = 1'b1;
          byte_d  = byte0;
        end else if (tmo_hit) begin
          state_d  = DONE;
          to_abort = 1'b1;
        end
      end
      WAIT0: begin
        if (saw_low_q && i_MOSI_Ready) begin
          state_d = SEND1;
        end else if (tmo_hit) begin
          state_d  = DONE;
          to_abort = 1'b1;
        end
      end
      SEND1: begin
        if (i_MOSI_Ready) begin
          state_d = WAIT_RX;
          dv_d    = 1'b1;
          byte_d  = byte1;
        end else if (tmo_hit) begin
          state_d  = DONE;
          to_abort = 1'b1;
        end
      end
      WAIT_RX: begin
        if (rx_sum >= 3'd2) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d  = DONE;
          to_abort = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q         <= 1'b0;
      addr_q       <= 7'd0;
      wdata_q      <= 8'd0;
      rx_cnt_q     <= 2'd0;
      tmo_q        <= '0;
      saw_low_q    <= 1'b0;
      abort_q      <= 1'b0;
      rx_hold_q    <= 8'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_rdata      <= 8'd0;
      o_MOSI_Count <= CW'(2);
      o_MOSI_Byte  <= 8'd0;
      o_MOSI_DV    <= 1'b0;
    end else begin
      if (accept) begin
        rw_q    <= i_rw;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
      end

      // MISO pulses in IDLE are ignored; the count restarts on accept.
      if (accept)
        rx_cnt_q <= 2'd0;
      else if ((state_q != IDLE) && i_MISO_DV)
        rx_cnt_q <= (rx_sum > 3'd3) ? 2'd3 : rx_sum[1:0];

      if ((state_d != state_q) || !in_wait) tmo_q <= '0;
      else                                  tmo_q <= tmo_q + TW'(1);

      if ((state_q == WAIT0) && (state_d == WAIT0))
        saw_low_q <= saw_low_q | ~i_MOSI_Ready;
      else
        saw_low_q <= 1'b0;

      if (accept)        abort_q <= 1'b0;
      else if (to_abort) abort_q <= 1'b1;

      // Second MISO byte is staged and only published on a clean completion.
      if (in_wait && i_MISO_DV && (rx_cnt_q == 2'd1))
        rx_hold_q <= i_MISO_Byte;
      if ((state_q == DONE) && !abort_q && rw_q)
        o_rdata <= rx_hold_q;

      o_busy       <= (state_d != IDLE);
      o_done       <= (state_q == DONE);
      o_err        <= (state_q == DONE) && abort_q;
      o_MOSI_Count <= CW'(2);
      o_MOSI_Byte  <= byte_d;
      o_MOSI_DV    <= dv_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: behavioural SPI-master/slave model plus a
// transaction-level reference for bytes, completion, error and read data.
module tb_spi_reg_ctrl;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic          i_rw;
  logic [6:0]    i_addr;
  logic [7:0]    i_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [7:0]    o_rdata;
  logic [CW-1:0] o_MOSI_Count;
  logic [7:0]    o_MOSI_Byte;
  logic          o_MOSI_DV;
  logic          i_MOSI_Ready;
  logic          i_MISO_DV;
  logic [7:0]    i_MISO_Byte;
  logic [CW-1:0] i_MISO_Count;

  // Master model state
  logic          m_ready;
  logic          m_dv;
  logic [7:0]    m_byte;
  logic          tie_low;
  logic          stray_dv;
  int            timer;
  int            gap;
  int            rx_idx;
  logic [7:0]    resp0;
  logic [7:0]    resp1;
  logic [7:0]    mosi_q[$];
  int            last_rx_cyc;
  int            cyc = 0;
  logic          prev_dv;

  logic [7:0]    exp_rdata;
  int            n_checks = 0;
  int            n_fail = 0;

  assign i_MOSI_Ready = m_ready & ~tie_low;
  assign i_MISO_DV    = m_dv | stray_dv;
  assign i_MISO_Byte  = stray_dv ? 8'hEE : m_byte;
  assign i_MISO_Count = 2'(rx_idx);

  spi_reg_ctrl #(
    .MAX_BYTES_PER_CS(2),
    .DUMMY_BYTE(8'h00),
    .TIMEOUT_CLKS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req(i_req),
    .i_rw(i_rw),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_rdata(o_rdata),
    .o_MOSI_Count(o_MOSI_Count),
    .o_MOSI_Byte(o_MOSI_Byte),
    .o_MOSI_DV(o_MOSI_DV),
    .i_MOSI_Ready(i_MOSI_Ready),
    .i_MISO_DV(i_MISO_DV),
    .i_MISO_Byte(i_MISO_Byte),
    .i_MISO_Count(i_MISO_Count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SPI master + slave: ready drops on a DV, one MISO byte per MOSI byte
  // after a random byte time, then a random CS-inactive gap after byte 2.
  initial begin
    m_ready = 1'b1; m_dv = 1'b0; m_byte = 8'h00;
    timer = 0; gap = 0; rx_idx = 0; last_rx_cyc = 0;
    forever begin
      @(negedge clk);
      m_dv = 1'b0;
      if (!rst) begin
        m_ready = 1'b1; timer = 0; gap = 0; rx_idx = 0;
      end else begin
        if (timer > 0) begin
          timer--;
          if (timer == 0) begin
            m_dv        = 1'b1;
            m_byte      = (rx_idx == 0) ? resp0 : resp1;
            last_rx_cyc = cyc;
            rx_idx++;
            if (rx_idx >= 2) begin
              rx_idx  = 0;
              gap     = $urandom_range(0, 3);
              m_ready = (gap == 0);
            end else begin
              m_ready = 1'b1;
            end
          end
        end else if (gap > 0) begin
          gap--;
          if (gap == 0) m_ready = 1'b1;
        end
        if (o_MOSI_DV) begin
          mosi_q.push_back(o_MOSI_Byte);
          m_ready = 1'b0;
          timer   = $urandom_range(2, 6);
        end
      end
    end
  end

  // DV pulses must never be adjacent.
  initial begin
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (o_MOSI_DV && rst) chk("dv_gap", 32'(prev_dv), 0);
      prev_dv = o_MOSI_DV;
    end
  end

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (o_done !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // One full transaction from a negedge; returns at the negedge after o_done.
  task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                         input logic [7:0] r0, input logic [7:0] r1, input logic stray);
    logic [7:0] b0, b1, old_rd, new_rd;
    logic       rdy_s0;
    int         n, bad;
    b0     = {rw, addr};
    b1     = rw ? 8'h00 : wdata;
    old_rd = exp_rdata;
    new_rd = rw ? r1 : exp_rdata;
    resp0  = r0;
    resp1  = r1;
    mosi_q.delete();
    i_req = 1'b1; i_rw = rw; i_addr = addr; i_wdata = wdata; stray_dv = stray;
    @(negedge clk);
    chk("busy_accept", 32'(o_busy), 1);
    i_req = 1'b0; stray_dv = 1'b0;
    i_rw = 1'($urandom); i_addr = 7'($urandom); i_wdata = 8'($urandom);
    #1 rdy_s0 = i_MOSI_Ready;
    @(negedge clk);
    if (rdy_s0) begin
      chk("first_dv", 32'(o_MOSI_DV), 1);
      chk("first_byte", 32'(o_MOSI_Byte), 32'(b0));
    end
    n = 0; bad = 0;
    while (o_done !== 1'b1 && n < 200) begin
      if (o_rdata !== old_rd && o_rdata !== new_rd) bad++;
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(o_done), 1);
    chk("err", 32'(o_err), 0);
    chk("busy_at_done", 32'(o_busy), 0);
    chk("done_latency", 32'(cyc - last_rx_cyc), 2);
    chk("rdata", 32'(o_rdata), 32'(new_rd));
    chk("rdata_glitch", 32'(bad), 0);
    chk("mosi_n", 32'(mosi_q.size()), 2);
    if (mosi_q.size() == 2) begin
      chk("mosi_b0", 32'(mosi_q[0]), 32'(b0));
      chk("mosi_b1", 32'(mosi_q[1]), 32'(b1));
    end
    exp_rdata = new_rd;
    @(negedge clk);
    chk("done_pulse", 32'(o_done), 0);
  endtask

  initial begin
    int n, nb, ndv;
    i_req = 1'b0; i_rw = 1'b0; i_addr = 7'd0; i_wdata = 8'd0;
    tie_low = 1'b0; stray_dv = 1'b0; resp0 = 8'h00; resp1 = 8'h00;
    exp_rdata = 8'h00;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_dv", 32'(o_MOSI_DV), 0);
    chk("rst_rdata", 32'(o_rdata), 0);
    chk("rst_byte", 32'(o_MOSI_Byte), 0);
    chk("rst_count", 32'(o_MOSI_Count), 2);
    rst = 1'b1;
    @(negedge clk);

    // Write with loopback MISO, then a read with a slave answer
    run_txn(1'b0, 7'h0F, 8'h2A, 8'h0F, 8'h2A, 1'b0);
    run_txn(1'b1, 7'h75, 8'h00, 8'hFF, 8'h68, 1'b0);

    // Busy collision: request held high with address changing mid-flight
    mosi_q.delete(); resp0 = 8'h11; resp1 = 8'h22;
    i_req = 1'b1; i_rw = 1'b0; i_addr = 7'h11; i_wdata = 8'hA1;
    repeat (3) @(negedge clk);
    i_addr = 7'h22; i_wdata = 8'hB2;
    wait_done(n);
    chk("col_done1", 32'(o_done), 1);
    chk("col_n1", 32'(mosi_q.size()), 2);
    if (mosi_q.size() == 2) begin
      chk("col_b0_1", 32'(mosi_q[0]), 32'h11);
      chk("col_b1_1", 32'(mosi_q[1]), 32'hA1);
    end
    mosi_q.delete();
    @(negedge clk);
    i_req = 1'b0;
    chk("col_busy2", 32'(o_busy), 1);
    wait_done(n);
    chk("col_done2", 32'(o_done), 1);
    chk("col_n2", 32'(mosi_q.size()), 2);
    if (mosi_q.size() == 2) begin
      chk("col_b0_2", 32'(mosi_q[0]), 32'h22);
      chk("col_b1_2", 32'(mosi_q[1]), 32'hB2);
    end
    chk("col_rdata", 32'(o_rdata), 32'(exp_rdata));
    @(negedge clk);

    // Timeout with the master never ready
    tie_low = 1'b1; mosi_q.delete();
    i_req = 1'b1; i_rw = 1'b1; i_addr = 7'h10; i_wdata = 8'h55;
    @(negedge clk);
    i_req = 1'b0;
    n = 0; nb = 0;
    while (o_done !== 1'b1 && n < 100) begin
      if (o_busy) nb++;
      @(negedge clk);
      n++;
    end
    chk("to_done", 32'(o_done), 1);
    chk("to_err", 32'(o_err), 1);
    chk("to_busy_cycles", 32'(nb), 17);
    chk("to_no_dv", 32'(mosi_q.size()), 0);
    chk("to_rdata", 32'(o_rdata), 32'(exp_rdata));
    @(negedge clk);
    tie_low = 1'b0;
    @(negedge clk);

    // Stray MISO pulses in IDLE, including on the accept cycle
    stray_dv = 1'b1;
    @(negedge clk);
    stray_dv = 1'b0;
    run_txn(1'b1, 7'h02, 8'h9C, 8'h44, 8'h33, 1'b1);

    // Reset while waiting for the read data
    resp0 = 8'hC3; resp1 = 8'h3C; mosi_q.delete();
    i_req = 1'b1; i_rw = 1'b1; i_addr = 7'h33;
    @(negedge clk);
    i_req = 1'b0;
    n = 0; ndv = 0;
    while (ndv < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (o_MOSI_DV) ndv++;
    end
    chk("mid_two_dv", 32'(ndv), 2);
    #1 rst = 1'b0;
    #1;
    chk("mid_busy", 32'(o_busy), 0);
    chk("mid_done", 32'(o_done), 0);
    chk("mid_err", 32'(o_err), 0);
    chk("mid_dv", 32'(o_MOSI_DV), 0);
    chk("mid_rdata", 32'(o_rdata), 0);
    chk("mid_byte", 32'(o_MOSI_Byte), 0);
    chk("mid_count", 32'(o_MOSI_Count), 2);
    exp_rdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 7'h01, 8'h00, 8'($urandom), 8'h5A, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
